sr_latch_bank: RTL and testbench
================================

Name: sr_latch_bank

Overview:
- Parametrised, clocked successor to the discrete cross-coupled NOR set/reset cell.
- Provides N_CH independent synchronous set/reset storage channels behind input synchronisers.
- Selectable S&R conflict resolution; the forbidden state is never produced.
- Per-channel change flags and saturating set-event counters for pad-level debug on the Tiny Tapeout wrapper.

Parameters:
- N_CH, 8, number of independent channels.
- SYNC_STAGES, 2, synchroniser flops on each s/r input; legal range 0..3, 0 = bypass (inputs already synchronous).
- CNT_W, 4, width of each per-channel set-event counter.
- CONFLICT_MODE, 0, behaviour when s and r are both asserted: 0 reset-dominant, 1 set-dominant, 2 toggle, 3 hold.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- s  input  N_CH  per-channel set request, level-sensitive, asynchronous to clk
- r  input  N_CH  per-channel reset request, level-sensitive, asynchronous to clk
- clr_flags  input  1  synchronous clear of chg and set_cnt, not synchronised
- q  output  N_CH  stored state
- qn  output  N_CH  always exactly ~q; no both-high/both-low state exists
- chg  output  N_CH  sticky: q changed since last reset/clr_flags
- conflict  output  N_CH  one-cycle pulse per cycle that synchronised s and r are both 1
- set_cnt  output  N_CH*CNT_W  channel i in bits [i*CNT_W +: CNT_W], count of q 0->1 transitions, saturating

Behaviour:
- Reset: rst=1 at a clock edge forces q=0, qn=1, chg=0, conflict=0, set_cnt=0, all sync flops=0. Reset has priority over everything, including mid-update. With rst held, outputs stay at reset values.
- Synchroniser: ss/rs are s/r delayed by SYNC_STAGES flops. Latency from input change to q change = SYNC_STAGES+1 cycles (3 at default).
- Next-state per channel from (ss, rs):
  - 00: hold.
  - 10: q<=1.
  - 01: q<=0.
  - 11 with mode 0: q<=0.
  - 11 with mode 1: q<=1.
  - 11 with mode 2: q<=~q every cycle while both held.
  - 11 with mode 3: hold.
- Level-sensitive: holding s keeps q=1; no edge detection on inputs.
- conflict[i] registered, =1 in the same cycle q reflects the 11 decision; never sticky.
- chg[i] <= 1 on any cycle q[i] changes; otherwise holds until clr_flags.
- set_cnt[i] increments by 1 on every q 0->1 transition; saturates at 2^CNT_W-1 (15 at default), no wrap.
- clr_flags simultaneous with a q change: the change wins. chg=1, and set_cnt=1 if the change was 0->1, else 0.
- clr_flags does not affect q, qn or conflict.
- Channels are fully independent; no cross-channel priority.
- Illegal parameter values (SYNC_STAGES>3, CONFLICT_MODE>3, CNT_W<1) are a static elaboration error.

Decomposition:
- Package sr_bank_pkg holds:
  - mode constants MODE_RST_DOM=0, MODE_SET_DOM=1, MODE_TOGGLE=2, MODE_HOLD=3;
  - a localparam helper for counter max.
- One sub-module sr_cell, instantiated N_CH times via generate. It holds one channel's synchroniser, next-state logic, chg flag and counter.
- sr_latch_bank itself contains only generate, packing and parameter checks.

Test Plan:
- Reset/latency: rst 2 cycles, then s[0]=1 at cycle 0 -> q[0]=1, qn[0]=0, chg[0]=1, set_cnt[0]=1 at cycle 3. All other channels stay q=0, qn=1.
- Conflict modes: s[1]=r[1]=1 for 4 cycles, q[1] initially 1:
  - mode 0 -> q=0;
  - mode 1 -> q=1;
  - mode 2 -> q sequence 0,1,0,1;
  - mode 3 -> q=1.
  - In every mode conflict[1]=1 for exactly 4 cycles.
- Saturation: pulse s[2] then r[2] 20 times (mode 0, CNT_W=4) -> set_cnt[2]=15, not 4.
- clr_flags collision: clr_flags=1 in the same cycle q[3] rises 0->1 -> next cycle chg[3]=1, set_cnt[3]=1. clr_flags with no change -> chg=0, set_cnt=0, q unchanged.
- Reset mid-operation: rst asserted while s[4] is in flight in the synchroniser -> q[4]=0 after the edge. Deassert rst with s[4] still high -> q[4]=1 SYNC_STAGES+1 cycles later.
- Bypass: SYNC_STAGES=0, r[5] rises -> q[5]=0 on the next edge (latency 1). Invariant qn==~q checked every cycle on all channels.

Source files
------------

// File: rtl/sr_latch_bank_pkg.sv
// Shared constants for the set/reset storage bank.
// Latency: none (declarations only).
// Backpressure: none.
package sr_bank_pkg;

    // What a channel does when synchronised s and r are both high.
    localparam int MODE_RST_DOM = 0;
    localparam int MODE_SET_DOM = 1;
    localparam int MODE_TOGGLE  = 2;
    localparam int MODE_HOLD    = 3;

    // Largest value a saturating counter of the given width can hold.
    function automatic int cnt_max(input int w);
        return (1 << w) - 1;
    endfunction

endpackage

// File: rtl/sr_latch_bank_if.sv
// Request/status bundle of the set/reset bank.
// Latency: none (wiring only).
// Backpressure: none; all signals are levels or single-cycle pulses.
interface sr_latch_bank_if #(
    parameter int N_CH  = 8,
    parameter int CNT_W = 4
);
    logic [N_CH-1:0]       s;
    logic [N_CH-1:0]       r;
    logic                  clr_flags;
    logic [N_CH-1:0]       q;
    logic [N_CH-1:0]       qn;
    logic [N_CH-1:0]       chg;
    logic [N_CH-1:0]       conflict;
    logic [N_CH*CNT_W-1:0] set_cnt;

    modport master (
        output s, r, clr_flags,
        input  q, qn, chg, conflict, set_cnt
    );

    modport slave (
        input  s, r, clr_flags,
        output q, qn, chg, conflict, set_cnt
    );
endinterface

// File: rtl/sr_latch_bank_cell.sv
// One storage channel: s/r synchroniser, next-state decision, change flag, set counter.
// Latency: input change reaches q after SYNC_STAGES+1 rising edges.
// Backpressure: none; inputs are levels, sampled every cycle.
module sr_cell
    import sr_bank_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int CNT_W         = 4,
    parameter int CONFLICT_MODE = MODE_RST_DOM
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_i,
    input  logic             r_i,
    input  logic             clr_flags_i,
    output logic             q_o,
    output logic             qn_o,
    output logic             chg_o,
    output logic             conflict_o,
    output logic [CNT_W-1:0] set_cnt_o
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

    logic             ss, rs;
    logic             q_q, q_d;
    logic             conflict_q, conflict_d;
    logic             chg_q, chg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rise, changed;

    generate
        if (SYNC_STAGES == 0) begin : g_bypass
            assign ss = s_i;
            assign rs = r_i;
        end else begin : g_sync
            logic [1:0] sync_q [SYNC_STAGES];

            // Shift the {s,r} pair down the synchroniser chain.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= 2'b00;
                end else begin
                    sync_q[0] <= {s_i, r_i};
                    for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
                end
            end

            assign {ss, rs} = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    // Decide next q, flag conflicts, and derive the change flag and counter updates.
    always_comb begin
        q_d        = q_q;
        conflict_d = 1'b0;
        case ({ss, rs})
            2'b10: q_d = 1'b1;
            2'b01: q_d = 1'b0;
            2'b11: begin
                conflict_d = 1'b1;
                if (CONFLICT_MODE == MODE_RST_DOM)      q_d = 1'b0;
                else if (CONFLICT_MODE == MODE_SET_DOM) q_d = 1'b1;
                else if (CONFLICT_MODE == MODE_TOGGLE)  q_d = ~q_q;
                else                                    q_d = q_q;
            end
            default: q_d = q_q;
        endcase

        rise    = q_d & ~q_q;
        changed = q_d ^ q_q;

        // A change in the clearing cycle survives the clear.
        chg_d = (chg_q & ~clr_flags_i) | changed;

        cnt_d = clr_flags_i ? '0 : cnt_q;
        if (rise && (cnt_d != CNT_MAX)) cnt_d = cnt_d + CNT_W'(1);
    end

    // State register; reset beats every other update.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q        <= 1'b0;
            conflict_q <= 1'b0;
            chg_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            q_q        <= q_d;
            conflict_q <= conflict_d;
            chg_q      <= chg_d;
            cnt_q      <= cnt_d;
        end
    end

    assign q_o        = q_q;
    assign qn_o       = ~q_q;
    assign chg_o      = chg_q;
    assign conflict_o = conflict_q;
    assign set_cnt_o  = cnt_q;
endmodule

// File: rtl/sr_latch_bank.sv
// Bank of N_CH independent clocked set/reset channels with debug flags and counters.
// Latency: SYNC_STAGES+1 cycles from s/r change to q change.
// Backpressure: none; every channel accepts its inputs every cycle.
module sr_latch_bank
    import sr_bank_pkg::*;
#(
    parameter int N_CH          = 8,
    parameter int SYNC_STAGES   = 2,
    parameter int CNT_W         = 4,
    parameter int CONFLICT_MODE = MODE_RST_DOM
) (
    input  logic              clk,
    input  logic              rst,
    sr_latch_bank_if.slave    bus
);
    generate
        if (SYNC_STAGES < 0 || SYNC_STAGES > 3) begin : g_bad_sync
            $error("sr_latch_bank: SYNC_STAGES must be 0..3");
        end
        if (CONFLICT_MODE < MODE_RST_DOM || CONFLICT_MODE > MODE_HOLD) begin : g_bad_mode
            $error("sr_latch_bank: CONFLICT_MODE must be 0..3");
        end
        if (CNT_W < 1) begin : g_bad_cnt
            $error("sr_latch_bank: CNT_W must be at least 1");
        end
    endgenerate

    logic [N_CH-1:0]       q_w, qn_w, chg_w, conflict_w;
    logic [N_CH*CNT_W-1:0] cnt_w;

    generate
        for (genvar g = 0; g < N_CH; g++) begin : g_ch
            sr_cell #(
                .SYNC_STAGES   (SYNC_STAGES),
                .CNT_W         (CNT_W),
                .CONFLICT_MODE (CONFLICT_MODE)
            ) u_cell (
                .clk         (clk),
                .rst         (rst),
                .s_i         (bus.s[g]),
                .r_i         (bus.r[g]),
                .clr_flags_i (bus.clr_flags),
                .q_o         (q_w[g]),
                .qn_o        (qn_w[g]),
                .chg_o       (chg_w[g]),
                .conflict_o  (conflict_w[g]),
                .set_cnt_o   (cnt_w[g*CNT_W +: CNT_W])
            );
        end
    endgenerate

    assign bus.q        = q_w;
    assign bus.qn       = qn_w;
    assign bus.chg      = chg_w;
    assign bus.conflict = conflict_w;
    assign bus.set_cnt  = cnt_w;
endmodule

// File: tb/tb_sr_latch_bank.sv
// Directed bench: one bank per conflict mode plus a bypass-synchroniser bank, shared stimulus.
// Latency: n/a.
// Backpressure: n/a.
module tb_sr_latch_bank;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] s_drv, r_drv;
    logic       clr_drv;
    logic       inv_en = 1'b0;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    sr_latch_bank_if #(.N_CH(8), .CNT_W(4)) if0 ();
    sr_latch_bank_if #(.N_CH(8), .CNT_W(4)) if1 ();
    sr_latch_bank_if #(.N_CH(8), .CNT_W(4)) if2 ();
    sr_latch_bank_if #(.N_CH(8), .CNT_W(4)) if3 ();
    sr_latch_bank_if #(.N_CH(8), .CNT_W(4)) ifb ();

    assign if0.s = s_drv; assign if0.r = r_drv; assign if0.clr_flags = clr_drv;
    assign if1.s = s_drv; assign if1.r = r_drv; assign if1.clr_flags = clr_drv;
    assign if2.s = s_drv; assign if2.r = r_drv; assign if2.clr_flags = clr_drv;
    assign if3.s = s_drv; assign if3.r = r_drv; assign if3.clr_flags = clr_drv;
    assign ifb.s = s_drv; assign ifb.r = r_drv; assign ifb.clr_flags = clr_drv;

    sr_latch_bank #(.N_CH(8), .SYNC_STAGES(2), .CNT_W(4), .CONFLICT_MODE(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    sr_latch_bank #(.N_CH(8), .SYNC_STAGES(2), .CNT_W(4), .CONFLICT_MODE(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
    sr_latch_bank #(.N_CH(8), .SYNC_STAGES(2), .CNT_W(4), .CONFLICT_MODE(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));
    sr_latch_bank #(.N_CH(8), .SYNC_STAGES(2), .CNT_W(4), .CONFLICT_MODE(3)) dut3 (.clk(clk), .rst(rst), .bus(if3));
    sr_latch_bank #(.N_CH(8), .SYNC_STAGES(0), .CNT_W(4), .CONFLICT_MODE(0)) dutb (.clk(clk), .rst(rst), .bus(ifb));

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] cnt_of(input logic [31:0] v, input int i);
        return v[i*4 +: 4];
    endfunction

    // qn must be the exact complement of q on every bank, every cycle.
    always @(negedge clk) begin
        if (inv_en) begin
            check("inv0", {24'd0, if0.qn}, {24'd0, ~if0.q});
            check("inv1", {24'd0, if1.qn}, {24'd0, ~if1.q});
            check("inv2", {24'd0, if2.qn}, {24'd0, ~if2.q});
            check("inv3", {24'd0, if3.qn}, {24'd0, ~if3.q});
            check("invb", {24'd0, ifb.qn}, {24'd0, ~ifb.q});
        end
    end

    initial begin
        logic [3:0] m2_exp;
        rst = 1'b1; s_drv = '0; r_drv = '0; clr_drv = 1'b0;
        repeat (2) tick();

        // Reset state
        check("rst_q",    {24'd0, if0.q},        32'h00);
        check("rst_qn",   {24'd0, if0.qn},       32'hff);
        check("rst_chg",  {24'd0, if0.chg},      32'h00);
        check("rst_conf", {24'd0, if0.conflict}, 32'h00);
        check("rst_cnt",  if0.set_cnt,           32'h0);
        check("rst_qb",   {24'd0, ifb.q},        32'h00);
        inv_en = 1'b1;

        // Latency through the synchroniser
        rst = 1'b0; s_drv[0] = 1'b1;
        tick();
        check("lat_e1",  {24'd0, if0.q}, 32'h00);
        check("byp_lat", {31'd0, ifb.q[0]}, 32'h1);
        tick();
        check("lat_e2",  {24'd0, if0.q}, 32'h00);
        tick();
        check("lat_q",   {24'd0, if0.q},   32'h01);
        check("lat_qn",  {24'd0, if0.qn},  32'hfe);
        check("lat_chg", {24'd0, if0.chg}, 32'h01);
        check("lat_cnt", if0.set_cnt,      32'h1);
        s_drv[0] = 1'b0;

        // Conflict modes on channel 1, q starts at 1
        s_drv[1] = 1'b1;
        tick();
        r_drv[1] = 1'b1;
        tick();
        tick();
        check("cf_pre_m0", {31'd0, if0.q[1]}, 32'h1);
        check("cf_pre_m2", {31'd0, if2.q[1]}, 32'h1);
        check("cf_pre_c",  {24'd0, if0.conflict}, 32'h00);
        m2_exp = 4'b1010; // per-cycle toggle 0,1,0,1 (bit i = cycle i)
        for (int i = 0; i < 4; i++) begin
            tick();
            check("cf_c_m0", {24'd0, if0.conflict}, 32'h02);
            check("cf_c_m1", {24'd0, if1.conflict}, 32'h02);
            check("cf_c_m2", {24'd0, if2.conflict}, 32'h02);
            check("cf_c_m3", {24'd0, if3.conflict}, 32'h02);
            check("cf_q_m0", {31'd0, if0.q[1]}, 32'h0);
            check("cf_q_m1", {31'd0, if1.q[1]}, 32'h1);
            check("cf_q_m2", {31'd0, if2.q[1]}, {31'd0, m2_exp[i]});
            check("cf_q_m3", {31'd0, if3.q[1]}, 32'h1);
            if (i == 1) begin
                s_drv[1] = 1'b0;
                r_drv[1] = 1'b0;
            end
        end
        tick();
        check("cf_end_c0", {24'd0, if0.conflict}, 32'h00);
        check("cf_end_c2", {24'd0, if2.conflict}, 32'h00);
        check("cf_end_m0", {31'd0, if0.q[1]}, 32'h0);
        check("cf_end_m2", {31'd0, if2.q[1]}, 32'h1);

        // Counter saturation on channel 2
        for (int p = 0; p < 20; p++) begin
            s_drv[2] = 1'b1;
            tick();
            s_drv[2] = 1'b0; r_drv[2] = 1'b1;
            tick();
            r_drv[2] = 1'b0;
        end
        repeat (4) tick();
        check("sat_cnt2",  {28'd0, cnt_of(if0.set_cnt, 2)}, 32'd15);
        check("sat_cntb",  {28'd0, cnt_of(ifb.set_cnt, 2)}, 32'd15);
        check("sat_q2",    {31'd0, if0.q[2]}, 32'h0);
        check("sat_cnt0",  {28'd0, cnt_of(if0.set_cnt, 0)}, 32'd1);

        // clr_flags in the same cycle q[3] rises
        s_drv[3] = 1'b1;
        tick();
        tick();
        clr_drv = 1'b1;
        tick();
        clr_drv = 1'b0; s_drv[3] = 1'b0;
        check("clr_hit_chg", {24'd0, if0.chg}, 32'h08);
        check("clr_hit_cnt", if0.set_cnt,      32'h0000_1000);
        check("clr_hit_q",   {24'd0, if0.q},   32'h09);
        tick();
        clr_drv = 1'b1;
        tick();
        clr_drv = 1'b0;
        check("clr_idle_chg", {24'd0, if0.chg}, 32'h00);
        check("clr_idle_cnt", if0.set_cnt,      32'h0);
        check("clr_idle_q",   {24'd0, if0.q},   32'h09);

        // Reset while s[4] is inside the synchroniser
        s_drv[4] = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        check("mid_rst_q",   {24'd0, if0.q},   32'h00);
        check("mid_rst_chg", {24'd0, if0.chg}, 32'h00);
        check("mid_rst_cnt", if0.set_cnt,      32'h0);
        rst = 1'b0;
        tick();
        check("mid_e1", {24'd0, if0.q}, 32'h00);
        tick();
        check("mid_e2", {24'd0, if0.q}, 32'h00);
        tick();
        check("mid_e3", {24'd0, if0.q}, 32'h10);
        s_drv[4] = 1'b0;

        // Bypass synchroniser: single-cycle latency on channel 5
        s_drv[5] = 1'b1;
        tick();
        check("byp_set",   {31'd0, ifb.q[5]}, 32'h1);
        check("sync_set1", {31'd0, if0.q[5]}, 32'h0);
        s_drv[5] = 1'b0; r_drv[5] = 1'b1;
        tick();
        check("byp_rst",   {31'd0, ifb.q[5]}, 32'h0);
        r_drv[5] = 1'b0;
        tick();
        check("sync_set3", {31'd0, if0.q[5]}, 32'h1);
        tick();
        check("sync_rst4", {31'd0, if0.q[5]}, 32'h0);

        inv_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
